multi_cycle_control: RTL and testbench

- Sequencing FSM that turns the processor's datapath into a multi-cycle machine: one shared instruction/data memory port, one ALU reused for PC+4, branch target and execute.
- Takes the decoded opcode and datapath status; drives the PC, IR, register file, memory and ALU control strobes every cycle.
- Handles variable-latency memory (ready handshake with timeout), halt requests and illegal opcodes.

---
 rtl/multi_cycle_control.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// multi_cycle_control
//
// Sequencing FSM for a multi-cycle processor datapath. One shared
// instruction/data memory port and one ALU are time-multiplexed across
// FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK states. Memory accesses use a
// ready handshake guarded by a wait counter; a timeout, an unknown opcode or
// a halt request parks the FSM in HALT.
//
// Optional feature macro: PERF_COUNTERS_EN adds cycle_count / instr_count.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode              IR[31:26], valid from DECODE onward
//   zero, alu_neg       ALU status used by the branch condition
//   mem_ready           memory finished the current access this cycle
//   halt_req            stop at the next instruction boundary
//   pc_write, pc_src    PC load enable and source select
//   ir_write, iord      IR load, memory address select (0 PC, 1 ALUOut)
//   mem_read, mem_write memory request strobes
//   reg_write, reg_dst, mem_to_reg   register file writeback control
//   alu_src_a, alu_src_b, alu_op     ALU operand/operation select
//   state               current state encoding (debug)
//   halted, illegal, mem_err         halt status and sticky error flags
//   cycle_count, instr_count         (PERF_COUNTERS_EN only) 32-bit wrapping

module multi_cycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        alu_neg,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [3:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic        mem_err
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_RD    = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WR    = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_ADDI_EXEC = 4'd9;
  localparam logic [3:0] S_ADDI_WB   = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;
  localparam logic [3:0] S_HALT      = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam int              CW      = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0]   WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  logic [3:0]    state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          illegal_reg, illegal_next;
  logic          mem_err_reg, mem_err_next;

  logic          timeout;
  logic          wait_state;
  logic          branch_taken;

  // Last permitted wait cycle with no ready: mem_ready on this same cycle
  // still wins because it is tested first in each memory state.
  assign timeout    = (wait_cnt_reg == WAIT_LAST) && !mem_ready;
  assign wait_state = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                      (state_reg == S_MEM_WR);

  always_comb begin
    branch_taken = 1'b0;
    case (opcode)
      OP_BEQ:  branch_taken = zero;
      OP_BNE:  branch_taken = !zero;
      OP_BGTZ: branch_taken = !zero && !alu_neg;  // Rt is r0, so sign/zero of Rs decide
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    mem_err_next = mem_err_reg;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    ir_write     = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 3'b000;

    case (state_reg)
      S_FETCH: begin
        // halt_req only counts at the instruction boundary, before any
        // memory request for the next instruction goes out.
        if ((wait_cnt_reg == '0) && halt_req) begin
          state_next = S_HALT;
        end else begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
          end else if (timeout) begin
            state_next   = S_HALT;
            mem_err_next = 1'b1;
          end
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:           state_next = S_MEM_ADDR;
          OP_RTYPE:               state_next = S_R_EXEC;
          OP_BEQ, OP_BNE, OP_BGTZ: state_next = S_BRANCH;
          OP_ADDI:                state_next = S_ADDI_EXEC;
          OP_J:                   state_next = S_JUMP;
          default: begin
            state_next   = S_HALT;
            illegal_next = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_next = S_MEM_WB;
        end else if (timeout) begin
          state_next   = S_HALT;
          mem_err_next = 1'b1;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_next = S_FETCH;
        end else if (timeout) begin
          state_next   = S_HALT;
          mem_err_next = 1'b1;
        end
      end
      S_R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b010;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b001;
        pc_src     = 2'b01;
        pc_write   = branch_taken;
        state_next = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        state_next = S_FETCH;
      end
      S_HALT: begin
        // Error halts are terminal; a plain halt resumes when the request drops.
        if (!illegal_reg && !mem_err_reg && !halt_req) begin
          state_next = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase

    // Reset cycle: whatever state we were in, the datapath sees no strobes.
    if (reset) begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
    end
  end

  // The counter restarts on every state change, which covers entry into each
  // memory state; it only advances while a memory access is outstanding.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (state_next != state_reg) begin
      wait_cnt_next = '0;
    end else if (wait_state && !mem_ready) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
      illegal_reg  <= 1'b0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      illegal_reg  <= illegal_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  assign state   = state_reg;
  assign halted  = (state_reg == S_HALT) && !reset;
  assign illegal = illegal_reg;
  assign mem_err = mem_err_reg;

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count_reg;
  logic [31:0] instr_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_reg <= '0;
      instr_count_reg <= '0;
    end else begin
      if (state_reg != S_HALT) cycle_count_reg <= cycle_count_reg + 32'd1;
      if (ir_write)            instr_count_reg <= instr_count_reg + 32'd1;
    end
  end

  assign cycle_count = cycle_count_reg;
  assign instr_count = instr_count_reg;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed testbench for multi_cycle_control: walks each instruction class
// through the FSM and compares state, packed control strobes and status flags
// against hand-derived values every cycle.

module tb_multi_cycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero, alu_neg, mem_ready, halt_req;
  logic        pc_write, ir_write, iord, mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic        halted, illegal, mem_err;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count, instr_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multi_cycle_control #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .alu_neg(alu_neg),
    .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .halted(halted),
    .illegal(illegal), .mem_err(mem_err)
`ifdef PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  // {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
  //  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op}
  logic [15:0] strobes;
  assign strobes = {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};
  logic [2:0] flags;
  assign flags = {halted, illegal, mem_err};

  localparam logic [15:0] E_ZERO       = 16'h0000;
  localparam logic [15:0] E_FETCH_RDY  = {1'b1,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000};
  localparam logic [15:0] E_FETCH_WAIT = {1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000};
  localparam logic [15:0] E_DECODE     = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000};
  localparam logic [15:0] E_MEM_ADDR   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000};
  localparam logic [15:0] E_MEM_RD     = {1'b0,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000};
  localparam logic [15:0] E_MEM_WB     = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b000};
  localparam logic [15:0] E_MEM_WR     = {1'b0,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000};
  localparam logic [15:0] E_R_EXEC     = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b010};
  localparam logic [15:0] E_R_WB       = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,3'b000};
  localparam logic [15:0] E_ADDI_EXEC  = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000};
  localparam logic [15:0] E_ADDI_WB    = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000};
  localparam logic [15:0] E_BR_T       = {1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001};
  localparam logic [15:0] E_BR_N       = {1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001};
  localparam logic [15:0] E_JUMP       = {1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Inputs are driven at posedge+1; outputs are compared at posedge+4, then
  // the task advances to the next posedge+1.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] sb,
                     input logic [2:0] fl);
    #3;
    check({tag, "_state"},   {28'd0, state}, {28'd0, st});
    check({tag, "_strobes"}, {16'd0, strobes}, {16'd0, sb});
    check({tag, "_flags"},   {29'd0, flags}, {29'd0, fl});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #3;
    check({tag, "_rst_strobes"}, {16'd0, strobes}, 32'd0);
    check({tag, "_rst_halted"},  {31'd0, halted},  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_branch(input string tag, input logic [5:0] op, input logic z,
                            input logic n, input logic [15:0] exp_br);
    opcode = op; zero = z; alu_neg = n; mem_ready = 1'b1;
    cyc({tag, "_f"}, 4'd0, E_FETCH_RDY, 3'b000);
    cyc({tag, "_d"}, 4'd1, E_DECODE, 3'b000);
    cyc({tag, "_b"}, 4'd8, exp_br, 3'b000);
    $display("txn %s: op=%0h zero=%0b neg=%0b done", tag, op, z, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = 6'h00; zero = 1'b0; alu_neg = 1'b0;
    mem_ready = 1'b1; halt_req = 1'b0;
    @(posedge clk);
    #1;
    apply_reset("init");

    // R-type: 0,1,6,7
    opcode = 6'h00;
    cyc("rt_f", 4'd0, E_FETCH_RDY, 3'b000);
    cyc("rt_d", 4'd1, E_DECODE, 3'b000);
    cyc("rt_x", 4'd6, E_R_EXEC, 3'b000);
    cyc("rt_w", 4'd7, E_R_WB, 3'b000);
    $display("txn rtype done");

    // lw with two wait cycles in MEM_RD: 0,1,2,3,3,3,4
    opcode = 6'h23;
    cyc("lw_f", 4'd0, E_FETCH_RDY, 3'b000);
    cyc("lw_d", 4'd1, E_DECODE, 3'b000);
    cyc("lw_a", 4'd2, E_MEM_ADDR, 3'b000);
    mem_ready = 1'b0;
    cyc("lw_r0", 4'd3, E_MEM_RD, 3'b000);
    cyc("lw_r1", 4'd3, E_MEM_RD, 3'b000);
    mem_ready = 1'b1;
    cyc("lw_r2", 4'd3, E_MEM_RD, 3'b000);
    cyc("lw_w", 4'd4, E_MEM_WB, 3'b000);
    $display("txn lw done");

    // sw zero-wait: 0,1,2,5
    opcode = 6'h2B;
    cyc("sw_f", 4'd0, E_FETCH_RDY, 3'b000);
    cyc("sw_d", 4'd1, E_DECODE, 3'b000);
    cyc("sw_a", 4'd2, E_MEM_ADDR, 3'b000);
    cyc("sw_m", 4'd5, E_MEM_WR, 3'b000);
    $display("txn sw done");

    run_branch("beq_t",  6'h04, 1'b1, 1'b0, E_BR_T);
    run_branch("beq_n",  6'h04, 1'b0, 1'b0, E_BR_N);
    run_branch("bne_t",  6'h05, 1'b0, 1'b0, E_BR_T);
    run_branch("bgtz_n", 6'h07, 1'b0, 1'b1, E_BR_N);
    run_branch("bgtz_t", 6'h07, 1'b0, 1'b0, E_BR_T);

    opcode = 6'h08;
    cyc("addi_f", 4'd0, E_FETCH_RDY, 3'b000);
    cyc("addi_d", 4'd1, E_DECODE, 3'b000);
    cyc("addi_x", 4'd9, E_ADDI_EXEC, 3'b000);
    cyc("addi_w", 4'd10, E_ADDI_WB, 3'b000);
    $display("txn addi done");

    opcode = 6'h02;
    cyc("j_f", 4'd0, E_FETCH_RDY, 3'b000);
    cyc("j_d", 4'd1, E_DECODE, 3'b000);
    cyc("j_j", 4'd11, E_JUMP, 3'b000);
    $display("txn j done");

    // halt_req raised during DECODE: instruction completes, HALT at boundary
    opcode = 6'h00;
    cyc("hr_f", 4'd0, E_FETCH_RDY, 3'b000);
    halt_req = 1'b1;
    cyc("hr_d", 4'd1, E_DECODE, 3'b000);
    cyc("hr_x", 4'd6, E_R_EXEC, 3'b000);
    cyc("hr_w", 4'd7, E_R_WB, 3'b000);
    cyc("hr_f0", 4'd0, E_ZERO, 3'b000);
    cyc("hr_h0", 4'd12, E_ZERO, 3'b100);
    halt_req = 1'b0;
    cyc("hr_h1", 4'd12, E_ZERO, 3'b100);
    opcode = 6'h02;
    cyc("hr_rf", 4'd0, E_FETCH_RDY, 3'b000);
    cyc("hr_rd", 4'd1, E_DECODE, 3'b000);
    cyc("hr_rj", 4'd11, E_JUMP, 3'b000);
    $display("txn halt_req done");

    // FETCH timeout: 16 wait cycles then terminal HALT with mem_err
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc("to_f", 4'd0, E_FETCH_WAIT, 3'b000);
    cyc("to_h0", 4'd12, E_ZERO, 3'b101);
    halt_req = 1'b1;
    cyc("to_h1", 4'd12, E_ZERO, 3'b101);
    halt_req = 1'b0;
    cyc("to_h2", 4'd12, E_ZERO, 3'b101);
    $display("txn fetch_timeout done");
    apply_reset("to");

    // mem_ready on the very last permitted cycle wins over the timeout
    for (int i = 0; i < 15; i++) cyc("lr_f", 4'd0, E_FETCH_WAIT, 3'b000);
    mem_ready = 1'b1;
    cyc("lr_fr", 4'd0, E_FETCH_RDY, 3'b000);
    cyc("lr_d", 4'd1, E_DECODE, 3'b000);
    cyc("lr_j", 4'd11, E_JUMP, 3'b000);
    $display("txn late_ready done");

    // Illegal opcode: terminal HALT, halt_req ignored, reset clears
    opcode = 6'h3F;
    cyc("il_f", 4'd0, E_FETCH_RDY, 3'b000);
    cyc("il_d", 4'd1, E_DECODE, 3'b000);
    halt_req = 1'b1;
    cyc("il_h0", 4'd12, E_ZERO, 3'b110);
    halt_req = 1'b0;
    cyc("il_h1", 4'd12, E_ZERO, 3'b110);
    cyc("il_h2", 4'd12, E_ZERO, 3'b110);
    apply_reset("il");
    opcode = 6'h02;
    cyc("il_rf", 4'd0, E_FETCH_RDY, 3'b000);
    cyc("il_rd", 4'd1, E_DECODE, 3'b000);
    cyc("il_rj", 4'd11, E_JUMP, 3'b000);
    $display("txn illegal done");

    // Reset during a stalled MEM_WR aborts the store
    opcode = 6'h2B;
    cyc("ab_f", 4'd0, E_FETCH_RDY, 3'b000);
    cyc("ab_d", 4'd1, E_DECODE, 3'b000);
    cyc("ab_a", 4'd2, E_MEM_ADDR, 3'b000);
    mem_ready = 1'b0;
    cyc("ab_m", 4'd5, E_MEM_WR, 3'b000);
    apply_reset("ab");
    mem_ready = 1'b1;
    opcode = 6'h00;
    cyc("ab_rf", 4'd0, E_FETCH_RDY, 3'b000);
    cyc("ab_rd", 4'd1, E_DECODE, 3'b000);
    $display("txn reset_abort done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
